// File: rtl/ams_adc_seq_pkg.sv
// Shared types and default constants for the multi-channel SAR ADC sequencer.
package ams_adc_seq_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StConv   = 2'd2
    } state_e;

    localparam int unsigned DefNumCh     = 4;
    localparam int unsigned DefResBits   = 8;
    localparam int unsigned DefSettleCyc = 4;
    localparam int unsigned DefAvgLog2   = 2;

endpackage

// File: rtl/ams_sar_core.sv
// Single-channel SAR sequencer: SETTLE_CYC settle cycles with the DAC at zero, then RES_BITS
// MSB-first trial cycles. done_o marks the last trial cycle; result_o is valid with it.
// A start_i seen together with done_o chains straight into the next SETTLE.
module ams_sar_core
    import ams_adc_seq_pkg::*;
#(
    parameter int unsigned RES_BITS   = DefResBits,
    parameter int unsigned SETTLE_CYC = DefSettleCyc
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                cmp_i,
    output logic                idle_o,
    output logic                done_o,
    output logic [RES_BITS-1:0] dac_code_o,
    output logic [RES_BITS-1:0] result_o
);

    localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [RES_BITS-1:0] bit_q, bit_d;   // one-hot bit under trial
    logic [RES_BITS-1:0] acc_q, acc_d;   // bits decided so far
    logic [RES_BITS-1:0] trial;
    logic [RES_BITS-1:0] conv_res;

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state, DAC drive and bit decision.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        acc_d      = acc_q;
        dac_code_o = '0;
        done_o     = 1'b0;
        trial      = acc_q | bit_q;
        // Comparator high keeps the trial bit, low drops it.
        conv_res   = cmp_i ? trial : acc_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (cnt_q == CntW'(SETTLE_CYC - 1)) begin
                    state_d = StConv;
                    bit_d   = {1'b1, {(RES_BITS - 1){1'b0}}};
                    acc_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StConv: begin
                dac_code_o = trial;
                acc_d      = conv_res;
                bit_d      = bit_q >> 1;
                if (bit_q[0]) begin
                    done_o = 1'b1;
                    if (start_i) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign idle_o   = (state_q == StIdle);
    assign result_o = conv_res;

endmodule

// File: rtl/ams_adc_seq.sv
// Multi-channel SAR ADC sequencer: scans a latched channel mask once or continuously, drives
// the analog mux and trial DAC through ams_sar_core, and delivers one result per channel
// through a single-entry valid/ready holding register with a sticky overrun flag.
// Define AMS_ADC_AVG_EN to average 2^AVG_LOG2 back-to-back conversions per channel.
module ams_adc_seq
    import ams_adc_seq_pkg::*;
#(
    parameter int unsigned NUM_CH     = DefNumCh,
    parameter int unsigned RES_BITS   = DefResBits,
    parameter int unsigned SETTLE_CYC = DefSettleCyc,
    parameter int unsigned AVG_LOG2   = DefAvgLog2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [NUM_CH-1:0]         ch_mask_i,
    input  logic                      continuous_i,
    output logic                      busy_o,
    output logic [$clog2(NUM_CH)-1:0] ana_ch_sel_o,
    output logic [RES_BITS-1:0]       ana_dac_code_o,
    input  logic                      ana_cmp_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [RES_BITS-1:0]       res_data_o,
    output logic [$clog2(NUM_CH)-1:0] res_ch_o,
    output logic                      overrun_o,
    input  logic                      clear_overrun_i
);

    localparam int unsigned ChW = $clog2(NUM_CH);

`ifdef AMS_ADC_AVG_EN
    localparam int unsigned AvgLog2 = AVG_LOG2;
`else
    // Single conversion per channel: the averaging path collapses to a pass-through.
    localparam int unsigned AvgLog2 = AVG_LOG2 * 0;
`endif

    localparam int unsigned AvgN    = 1 << AvgLog2;
    localparam int unsigned SumW    = RES_BITS + AvgLog2;
    localparam int unsigned AvgCntW = (AvgLog2 > 0) ? AvgLog2 : 1;

    // Lowest set channel at or above lo; bit ChW is the found flag.
    function automatic logic [ChW:0] find_set(input logic [NUM_CH-1:0] mask, input int lo);
        logic [ChW:0] res;
        res = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (mask[i] && (i >= lo)) begin
                res = {1'b1, ChW'(i)};
            end
        end
        return res;
    endfunction

    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [ChW-1:0]      ch_q, ch_d;
    logic [AvgCntW-1:0]  avg_cnt_q, avg_cnt_d;
    logic [SumW-1:0]     sum_q, sum_d, sum_new;
    logic                valid_q, valid_d;
    logic [RES_BITS-1:0] data_q, data_d;
    logic [ChW-1:0]      res_ch_q, res_ch_d;
    logic                ovr_q, ovr_d;

    logic                core_start, core_idle, core_done;
    logic [RES_BITS-1:0] core_dac, core_result;
    logic                wr_en;
    logic [RES_BITS-1:0] wr_data;
    logic                accept, ovr_set;
    logic [ChW:0]        first_hit, next_hit, wrap_hit;

    ams_sar_core #(
        .RES_BITS   (RES_BITS),
        .SETTLE_CYC (SETTLE_CYC)
    ) u_core (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (core_start),
        .cmp_i      (ana_cmp_i),
        .idle_o     (core_idle),
        .done_o     (core_done),
        .dac_code_o (core_dac),
        .result_o   (core_result)
    );

    // Scan, averaging and holding registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q    <= '0;
            ch_q      <= '0;
            avg_cnt_q <= '0;
            sum_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            res_ch_q  <= '0;
            ovr_q     <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            ch_q      <= ch_d;
            avg_cnt_q <= avg_cnt_d;
            sum_q     <= sum_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            res_ch_q  <= res_ch_d;
            ovr_q     <= ovr_d;
        end
    end

    // Scan control: start a scan, repeat for averaging, step to the next channel or wrap.
    always_comb begin
        mask_d     = mask_q;
        ch_d       = ch_q;
        avg_cnt_d  = avg_cnt_q;
        sum_d      = sum_q;
        core_start = 1'b0;
        wr_en      = 1'b0;
        sum_new    = sum_q + SumW'(core_result);
        wr_data    = RES_BITS'(sum_new >> AvgLog2);
        first_hit  = find_set(ch_mask_i, 0);
        next_hit   = find_set(mask_q, int'(ch_q) + 1);
        wrap_hit   = find_set(mask_q, 0);
        if (core_idle) begin
            // Start requests are only honoured while idle; an empty mask is ignored.
            if (start_i && (|ch_mask_i)) begin
                core_start = 1'b1;
                mask_d     = ch_mask_i;
                ch_d       = first_hit[ChW-1:0];
                avg_cnt_d  = '0;
                sum_d      = '0;
            end
        end else if (core_done) begin
            if (avg_cnt_q != AvgCntW'(AvgN - 1)) begin
                core_start = 1'b1;
                avg_cnt_d  = avg_cnt_q + 1'b1;
                sum_d      = sum_new;
            end else begin
                wr_en     = 1'b1;
                avg_cnt_d = '0;
                sum_d     = '0;
                if (next_hit[ChW]) begin
                    core_start = 1'b1;
                    ch_d       = next_hit[ChW-1:0];
                end else if (continuous_i) begin
                    core_start = 1'b1;
                    ch_d       = wrap_hit[ChW-1:0];
                end
            end
        end
    end

    // Holding register: a write into an unaccepted entry is dropped and flags overrun.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        res_ch_d = res_ch_q;
        ovr_set  = 1'b0;
        accept   = valid_q & res_ready_i;
        if (accept) begin
            valid_d = 1'b0;
        end
        if (wr_en) begin
            if (valid_q && !accept) begin
                ovr_set = 1'b1;
            end else begin
                valid_d  = 1'b1;
                data_d   = wr_data;
                res_ch_d = ch_q;
            end
        end
        // Set beats clear when both happen together.
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clear_overrun_i) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    assign busy_o         = ~core_idle;
    assign ana_ch_sel_o   = ch_q;
    assign ana_dac_code_o = core_dac;
    assign res_valid_o    = valid_q;
    assign res_data_o     = data_q;
    assign res_ch_o       = res_ch_q;
    assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_ams_adc_seq.sv
// Directed bench for ams_adc_seq at default parameters (single-conversion build).
// The analog side is a behavioural comparator against a per-channel input value table.
module tb_ams_adc_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] ch_mask;
    logic       continuous;
    logic       busy;
    logic [1:0] ana_ch_sel;
    logic [7:0] ana_dac_code;
    logic       ana_cmp;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [1:0] res_ch;
    logic       overrun;
    logic       clear_overrun;

    logic [7:0] ana_val [4];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Ideal comparator: input at or above the trial code reads as 1.
    always_comb ana_cmp = (ana_val[ana_ch_sel] >= ana_dac_code);

    ams_adc_seq u_dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .ch_mask_i       (ch_mask),
        .continuous_i    (continuous),
        .busy_o          (busy),
        .ana_ch_sel_o    (ana_ch_sel),
        .ana_dac_code_o  (ana_dac_code),
        .ana_cmp_i       (ana_cmp),
        .res_valid_o     (res_valid),
        .res_ready_i     (res_ready),
        .res_data_o      (res_data),
        .res_ch_o        (res_ch),
        .overrun_o       (overrun),
        .clear_overrun_i (clear_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one edge; returns at the negedge right after that edge.
    task automatic start_scan(input logic [3:0] m);
        start   = 1'b1;
        ch_mask = m;
        step(1);
        start   = 1'b0;
    endtask

    // Bounded wait for res_valid; checks cycles taken against the expected latency.
    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!res_valid && n < 60);
        chk(tag, n, exp_lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ana_val[0] = 8'h00;
        ana_val[1] = 8'h00;
        ana_val[2] = 8'h00;
        ana_val[3] = 8'h00;

        // Reset with random stimulus on the control inputs.
        rst           = 1'b1;
        start         = 1'($urandom_range(0, 1));
        ch_mask       = 4'($urandom);
        continuous    = 1'($urandom_range(0, 1));
        res_ready     = 1'($urandom_range(0, 1));
        clear_overrun = 1'($urandom_range(0, 1));
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_data", res_data, 0);
        chk("rst_ch", res_ch, 0);
        chk("rst_sel", ana_ch_sel, 0);
        chk("rst_dac", ana_dac_code, 0);
        chk("rst_ovr", overrun, 0);
        rst           = 1'b0;
        start         = 1'b0;
        ch_mask       = 4'b0000;
        continuous    = 1'b0;
        res_ready     = 1'b1;
        clear_overrun = 1'b0;
        step(2);

        // Single channel 2 at 0xA5 with exact latency and trial codes.
        ana_val[2] = 8'hA5;
        start_scan(4'b0100);
        chk("a5_busy_s0", busy, 1);
        chk("a5_sel", ana_ch_sel, 2);
        for (int c = 1; c <= 12; c++) begin
            step(1);
            if (c == 3)  chk("a5_dac_settle", ana_dac_code, 8'h00);
            if (c == 4)  chk("a5_dac_k0", ana_dac_code, 8'h80);
            if (c == 5)  chk("a5_dac_k1", ana_dac_code, 8'hC0);
            if (c == 7)  chk("a5_dac_k3", ana_dac_code, 8'hB0);
            if (c == 11) chk("a5_valid_early", res_valid, 0);
        end
        chk("a5_valid", res_valid, 1);
        chk("a5_data", res_data, 8'hA5);
        chk("a5_ch", res_ch, 2);
        chk("a5_busy_end", busy, 0);
        step(1);
        chk("a5_accepted", res_valid, 0);

        // Full-scale boundaries on channel 0.
        ana_val[0] = 8'h00;
        start_scan(4'b0001);
        wait_valid("zero_lat", 12);
        chk("zero_data", res_data, 8'h00);
        chk("zero_ch", res_ch, 0);
        step(1);
        ana_val[0] = 8'hFF;
        start_scan(4'b0001);
        wait_valid("ff_lat", 12);
        chk("ff_data", res_data, 8'hFF);
        step(1);

        // Empty mask is ignored.
        start_scan(4'b0000);
        chk("mask0_busy_s0", busy, 0);
        step(3);
        chk("mask0_busy_s3", busy, 0);
        chk("mask0_valid", res_valid, 0);

        // Three-channel scan; a start pulse mid-scan must not disturb it.
        ana_val[0] = 8'h10;
        ana_val[1] = 8'h20;
        ana_val[2] = 8'h30;
        ana_val[3] = 8'h40;
        start_scan(4'b1011);
        wait_valid("scan_lat0", 12);
        chk("scan_data0", res_data, 8'h10);
        chk("scan_ch0", res_ch, 0);
        start   = 1'b1;
        ch_mask = 4'b0100;
        step(1);
        start   = 1'b0;
        chk("scan_sel1", ana_ch_sel, 1);
        wait_valid("scan_lat1", 11);
        chk("scan_data1", res_data, 8'h20);
        chk("scan_ch1", res_ch, 1);
        wait_valid("scan_lat3", 12);
        chk("scan_data3", res_data, 8'h40);
        chk("scan_ch3", res_ch, 3);
        chk("scan_busy_end", busy, 0);
        step(2);

        // Continuous scan with back-pressure: overrun, clear, then stop.
        ana_val[0] = 8'h5A;
        continuous = 1'b1;
        res_ready  = 1'b0;
        start_scan(4'b0001);
        step(12);
        chk("cont_valid1", res_valid, 1);
        chk("cont_data1", res_data, 8'h5A);
        chk("cont_ovr1", overrun, 0);
        ana_val[0] = 8'h33;
        step(12);
        chk("cont_ovr2", overrun, 1);
        chk("cont_hold_data", res_data, 8'h5A);
        chk("cont_busy2", busy, 1);
        clear_overrun = 1'b1;
        step(1);
        clear_overrun = 1'b0;
        continuous    = 1'b0;
        chk("cont_ovr_clr", overrun, 0);
        step(10);
        chk("cont_busy_last", busy, 1);
        step(1);
        chk("cont_busy_stop", busy, 0);
        chk("cont_ovr3", overrun, 1);
        chk("cont_hold_data3", res_data, 8'h5A);
        res_ready = 1'b1;
        step(1);
        chk("cont_drain", res_valid, 0);
        clear_overrun = 1'b1;
        step(1);
        clear_overrun = 1'b0;
        chk("cont_ovr_final", overrun, 0);

        // Reset during conversion cycle 3, then a clean restart.
        ana_val[0] = 8'h77;
        start_scan(4'b0001);
        step(7);
        chk("mid_dac_k3", ana_dac_code, 8'h70);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_dac", ana_dac_code, 0);
        chk("mid_valid", res_valid, 0);
        start_scan(4'b0001);
        wait_valid("restart_lat", 12);
        chk("restart_data", res_data, 8'h77);
        chk("restart_ch", res_ch, 0);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
